vce2_vrf_seq: RTL

VCE2_VRF_SEQ -- requirements
Module: vce2_vrf_seq

---
 rtl/vce2_pkg.sv | 29 ++
 rtl/vce2_vrf_seq.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/vce2_pkg.sv
// Shared definitions for the VCE2 vector datapath: default widths and the
// register-file sequencer state encoding.
package vce2_pkg;

  localparam int unsigned DefaultAddrWidth = 32;
  localparam int unsigned DefaultDataWidth = 32;
  localparam int unsigned DefaultVlWidth   = 8;

  typedef enum logic [3:0] {
    VRF_IDLE,
    VRF_LOAD,
    VRF_RD1,
    VRF_RD2,
    VRF_RD3,
    VRF_WAIT,
    VRF_EXEC,
    VRF_WR,
    VRF_DONE
  } vrf_state_e;

  // Which operand register the read data returning this cycle belongs to.
  typedef enum logic [1:0] {
    OPND_NONE,
    OPND_RS1,
    OPND_RS2,
    OPND_RD
  } opnd_sel_e;

endpackage

// File: rtl/vce2_vrf_seq.sv
// Vector register-file sequencer: per element, reads rs1/rs2/old rd through the
// AGU, hands the operands to the ALU and writes the result back to rd.
module vce2_vrf_seq
  import vce2_pkg::*;
#(
  parameter int unsigned AddrWidth = DefaultAddrWidth,
  parameter int unsigned DataWidth = DefaultDataWidth,
  parameter int unsigned VlWidth   = DefaultVlWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [VlWidth-1:0]   vl_i,
  input  logic                 use_rs2_i,
  input  logic                 use_rd_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 agu_load_o,
  output logic                 agu_get_rs1_o,
  output logic                 agu_get_rs2_o,
  output logic                 agu_get_rd_noincr_o,
  output logic                 agu_get_rd_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  input  logic [DataWidth-1:0] mem_rdata_i,
  output logic [DataWidth-1:0] alu_a_o,
  output logic [DataWidth-1:0] alu_b_o,
  output logic [DataWidth-1:0] alu_c_o,
  output logic                 alu_valid_o,
  input  logic                 alu_done_i,
  input  logic [DataWidth-1:0] alu_result_i
);

  // Addresses are produced by the AGU; they must at least span one word.
  if (AddrWidth < 2) begin : g_addr_width_check
    $error("vce2_vrf_seq: AddrWidth too small");
  end

  vrf_state_e           state_q, state_d;
  opnd_sel_e            rd_sel_q, rd_sel_d;
  logic [VlWidth-1:0]   cnt_q;
  logic                 use_rs2_q, use_rd_q;
  logic [DataWidth-1:0] a_q, b_q, c_q, res_q;

  // NOTE: every output and next-state signal gets a default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d             = state_q;
    rd_sel_d            = OPND_NONE;
    busy_o              = (state_q != VRF_IDLE);
    done_o              = 1'b0;
    agu_load_o          = 1'b0;
    agu_get_rs1_o       = 1'b0;
    agu_get_rs2_o       = 1'b0;
    agu_get_rd_noincr_o = 1'b0;
    agu_get_rd_o        = 1'b0;
    mem_req_o           = 1'b0;
    mem_we_o            = 1'b0;
    mem_wdata_o         = '0;
    alu_valid_o         = 1'b0;

    unique case (state_q)
      VRF_IDLE: begin
        if (start_i) state_d = VRF_LOAD;
      end
      VRF_LOAD: begin
        agu_load_o = 1'b1;
        state_d    = (cnt_q == '0) ? VRF_DONE : VRF_RD1;
      end
      VRF_RD1: begin
        mem_req_o     = 1'b1;
        agu_get_rs1_o = 1'b1;
        rd_sel_d      = OPND_RS1;
        state_d       = use_rs2_q ? VRF_RD2 : (use_rd_q ? VRF_RD3 : VRF_WAIT);
      end
      VRF_RD2: begin
        mem_req_o     = 1'b1;
        agu_get_rs2_o = 1'b1;
        rd_sel_d      = OPND_RS2;
        state_d       = use_rd_q ? VRF_RD3 : VRF_WAIT;
      end
      VRF_RD3: begin
        mem_req_o           = 1'b1;
        agu_get_rd_noincr_o = 1'b1;
        rd_sel_d            = OPND_RD;
        state_d             = VRF_WAIT;
      end
      VRF_WAIT: begin
        state_d = VRF_EXEC;
      end
      VRF_EXEC: begin
        alu_valid_o = 1'b1;
        if (alu_done_i) state_d = VRF_WR;
      end
      VRF_WR: begin
        mem_req_o    = 1'b1;
        mem_we_o     = 1'b1;
        agu_get_rd_o = 1'b1;
        mem_wdata_o  = res_q;
        state_d      = (cnt_q == VlWidth'(1)) ? VRF_DONE : VRF_RD1;
      end
      VRF_DONE: begin
        done_o  = 1'b1;
        state_d = VRF_IDLE;
      end
      default: state_d = VRF_IDLE;
    endcase
  end

  assign alu_a_o = a_q;
  assign alu_b_o = use_rs2_q ? b_q : '0;
  assign alu_c_o = use_rd_q  ? c_q : '0;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  // The datapath registers are few and explicitly cleared, so a reset leaves
  // no stale operand or result visible on the outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= VRF_IDLE;
      rd_sel_q  <= OPND_NONE;
      cnt_q     <= '0;
      use_rs2_q <= 1'b0;
      use_rd_q  <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      res_q     <= '0;
    end else begin
      state_q  <= state_d;
      rd_sel_q <= rd_sel_d;

      if (state_q == VRF_IDLE && start_i) begin
        cnt_q     <= vl_i;
        use_rs2_q <= use_rs2_i;
        use_rd_q  <= use_rd_i;
      end else if (state_q == VRF_WR) begin
        cnt_q <= cnt_q - VlWidth'(1);
      end

      if (state_q == VRF_EXEC && alu_done_i) res_q <= alu_result_i;

      // Read data arrives one cycle after its request, whatever state we are in.
      unique case (rd_sel_q)
        OPND_RS1: a_q <= mem_rdata_i;
        OPND_RS2: b_q <= mem_rdata_i;
        OPND_RD:  c_q <= mem_rdata_i;
        default: ;
      endcase
    end
  end

endmodule
